// File: rtl/instruction_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// Optional feature macro: PREFETCH_ABORT_EN (adds a per-entry abort bit).
package instruction_prefetch_buffer_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef logic [31:0] word_addr_t;

  typedef struct packed {
    logic [31:0] instr;
    word_addr_t  pc;
`ifdef PREFETCH_ABORT_EN
    logic        abort;
`endif
  } fetch_entry_t;

  typedef enum logic [0:0] {
    ST_RESET_HOLD = 1'b0,
    ST_RUN        = 1'b1
  } fetch_state_t;

  function automatic word_addr_t next_word_addr(input word_addr_t a);
    return a + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_prefetch_buffer_if.sv
// Memory-side and decode-side bus of the prefetch buffer.
// Optional feature macro: PREFETCH_ABORT_EN (adds abort / instr_abort).
interface instruction_prefetch_buffer_if;
  import instruction_prefetch_buffer_pkg::*;

  word_addr_t  addr;
  logic [1:0]  trans;
  logic        write;
  logic [31:0] rdata;
  logic        flush;
  word_addr_t  flush_pc;
  logic [31:0] instr;
  word_addr_t  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef PREFETCH_ABORT_EN
  logic        abort;
  logic        instr_abort;

  modport master (
    output addr, trans, write, instr, instr_pc, instr_valid, instr_abort,
    input  rdata, flush, flush_pc, instr_ready, abort
  );
  modport slave (
    input  addr, trans, write, instr, instr_pc, instr_valid, instr_abort,
    output rdata, flush, flush_pc, instr_ready, abort
  );
`else
  modport master (
    output addr, trans, write, instr, instr_pc, instr_valid,
    input  rdata, flush, flush_pc, instr_ready
  );
  modport slave (
    input  addr, trans, write, instr, instr_pc, instr_valid,
    output rdata, flush, flush_pc, instr_ready
  );
`endif

endinterface

// File: rtl/instruction_prefetch_buffer_chk.sv
// Checker for the prefetch FIFO: a push must never land in a full FIFO.
module instruction_prefetch_buffer_chk (
  input logic clk,
  input logic reset,
  input logic i_push,
  input logic i_clear,
  input logic i_full
);

  // The issue credit limit keeps count + pending within DEPTH, so a full FIFO never sees a push.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(i_push && !i_clear && i_full));

endmodule

// File: rtl/instruction_prefetch_buffer_fifo.sv
// Synchronous FIFO of fetch entries with clear; head entry is read combinationally.
module instruction_prefetch_buffer_fifo
  import instruction_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_data,
  input  logic                     i_pop,
  output fetch_entry_t             o_head,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LP_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] LP_ZERO = (PW+1)'(0);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_full;

  // Clear overrides both push and pop; popping an empty FIFO is ignored.
  always_comb begin
    w_full  = (r_count == LP_FULL);
    w_push  = i_push && !i_clear;
    w_pop   = i_pop && !i_clear && (r_count != LP_ZERO);
    o_head  = r_mem[r_rd_ptr];
    o_valid = (r_count != LP_ZERO);
    o_count = r_count;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_rd_ptr <= PW'(0);
      r_wr_ptr <= PW'(0);
      r_count  <= LP_ZERO;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  instruction_prefetch_buffer_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .i_push  (i_push),
    .i_clear (i_clear),
    .i_full  (w_full)
  );

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch stage: credit-limited word fetch, entry FIFO, flush/redirect.
// Optional feature macro: PREFETCH_ABORT_EN (per-entry abort, fetch stall until flush).
module instruction_prefetch_buffer
  import instruction_prefetch_buffer_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter word_addr_t RESET_PC = 32'h0
) (
  input logic                          clk,
  input logic                          reset,
  instruction_prefetch_buffer_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] LP_DEPTH = (PW+2)'(DEPTH);

  fetch_state_t  r_state;
  word_addr_t    r_fetch_pc;
  word_addr_t    r_req_pc;
  logic          r_pending;
  logic          r_seq;
  fetch_entry_t  w_push_data;
  fetch_entry_t  w_head;
  logic          w_head_valid;
  logic [PW:0]   w_count;
  logic [PW+1:0] w_occupancy;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_abort_stall;

`ifdef PREFETCH_ABORT_EN
  logic r_abort_hold;

  // Once an aborted word is captured, fetch stays stalled until a redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_abort_hold <= 1'b0;
    end else if (bus.flush) begin
      r_abort_hold <= 1'b0;
    end else if (w_push && bus.abort) begin
      r_abort_hold <= 1'b1;
    end
  end

  always_comb begin
    w_abort_stall = r_abort_hold;
  end
`else
  always_comb begin
    w_abort_stall = 1'b0;
  end
`endif

  // Credit counts the outstanding response, so the FIFO can never overflow.
  always_comb begin
    w_occupancy = {1'b0, w_count} + {{(PW+1){1'b0}}, r_pending};
    w_issue     = (r_state == ST_RUN) && !bus.flush && !reset && !w_abort_stall &&
                  (w_occupancy < LP_DEPTH);
    w_push      = r_pending && !bus.flush;
    w_pop       = w_head_valid && bus.instr_ready && !bus.flush;
    w_push_data.instr = bus.rdata;
    w_push_data.pc    = r_req_pc;
`ifdef PREFETCH_ABORT_EN
    w_push_data.abort = bus.abort;
    bus.instr_abort   = w_head.abort;
`endif
    if (w_issue) begin
      bus.trans = r_seq ? TRANS_SEQ : TRANS_NONSEQ;
    end else begin
      bus.trans = TRANS_IDLE;
    end
    bus.addr        = r_fetch_pc;
    bus.write       = 1'b0;
    bus.instr       = w_head.instr;
    bus.instr_pc    = w_head.pc;
    bus.instr_valid = w_head_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RESET_HOLD;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_pending  <= 1'b0;
      r_seq      <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET_HOLD: r_state <= ST_RUN;
        ST_RUN:        r_state <= ST_RUN;
        default:       r_state <= ST_RESET_HOLD;
      endcase
      r_pending <= w_issue;
      r_seq     <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_fetch_pc;
      end
      if (bus.flush) begin
        r_fetch_pc <= bus.flush_pc;
      end else if (w_issue) begin
        r_fetch_pc <= next_word_addr(r_fetch_pc);
      end
    end
  end

  instruction_prefetch_buffer_fifo #(.DEPTH(DEPTH)) u_prefetch_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (bus.flush),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (w_head_valid),
    .o_count     (w_count)
  );

endmodule

// File: doc/instruction_prefetch_buffer.md
Name: instruction_prefetch_buffer

Overview:
- Fetch stage between memory_controller and the processor decode pipeline.
- Issues word-addressed instruction reads and buffers returned words in a small FIFO with their PCs.
- Presents the head entry to decode through a valid/ready handshake.
- Flushes and redirects on a branch from execute, discarding in-flight and buffered words.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
RESET_PC, 32'h0, first word address fetched after reset.

Ports:
clk  input  1  clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
addr  output  32  word address to memory_controller; equals the fetch_pc register.
trans  output  2  2'b00 idle, 2'b10 non-sequential, 2'b11 sequential.
write  output  1  tied 0.
rdata  input  32  memory read data, valid the cycle after the request.
flush  input  1  branch redirect from execute.
flush_pc  input  32  redirect word address, sampled when flush=1.
instr  output  32  head instruction.
instr_pc  output  32  word address of head instruction.
instr_valid  output  1  head entry present.
instr_ready  input  1  decode accepts head this cycle.

Behaviour:
- Reset, synchronous and priority over everything:
  - fetch_pc=RESET_PC, FIFO empty (count=0, rd_ptr=wr_ptr=0), pending=0, seq=0.
  - Outputs: trans=2'b00, write=0, instr_valid=0; instr and instr_pc hold don't-care and are checked only when valid.
- Issue condition: !flush && !reset && (count + pending) < DEPTH, counting occupancy before this cycle's pop.
  - When met, trans = seq ? 2'b11 : 2'b10.
  - Otherwise trans=2'b00.
- On issue:
  - fetch_pc <= fetch_pc+1, with 32-bit wrap 32'hFFFFFFFF -> 0.
  - pending <= 1, req_pc <= fetch_pc, seq <= 1.
- On a non-issue cycle: pending <= 0, seq <= 0. The first request after any gap is non-sequential.
- Capture: if pending && !flush, push {rdata, req_pc} at wr_ptr. Pointers wrap modulo DEPTH.
- Pop: instr_valid && instr_ready advances rd_ptr.
  - Simultaneous push and pop leaves count unchanged.
  - Push into a full FIFO cannot occur because of the issue credit rule; assert it never happens.
- instr, instr_pc and instr_valid are driven combinationally from the head entry.
- Latency: request in cycle t gives instr_valid in cycle t+2 when the FIFO was empty. Steady-state throughput is 1 word/cycle while decode is ready.
- Flush in cycle f:
  - No request in f.
  - FIFO cleared; pending response arriving in f dropped; pops in f ignored.
  - fetch_pc <= flush_pc, seq <= 0.
  - Cycle f+1: NONSEQ request at flush_pc.
  - Cycle f+3: instr_valid with instr_pc=flush_pc.
- Flush and reset together: reset wins.
- Backpressure: with instr_ready=0, issue continues until count+pending=DEPTH, then trans=2'b00 until a pop.
- State machine (2 states):
  - RESET_HOLD: one cycle after reset release, no issue. Moves to RUN.
  - RUN: issue, capture and flush as above. reset returns to RESET_HOLD.

Optional Feature:
- Macro PREFETCH_ABORT_EN.
- When defined:
  - Adds input abort (1 bit, valid alongside rdata) and output instr_abort (1 bit).
  - The abort bit is stored per entry and presented with the head entry.
  - Issue is suppressed, with fetch stalled at the address after the aborted one, while any stored entry has abort=1. Resumes only after flush.
- When undefined: no abort ports, no per-entry abort storage.

Decomposition:
- Shared package:
  - Trans encoding constants TRANS_IDLE=2'b00, TRANS_NONSEQ=2'b10, TRANS_SEQ=2'b11.
  - Fetch entry typedef {instr[31:0], pc[31:0]}, plus abort bit under PREFETCH_ABORT_EN.
  - Word-address type.
- One natural sub-module: prefetch_fifo, a parameterised synchronous FIFO holding push/pop/clear, pointers and count. The top level holds the PC, credit, trans and flush logic.

Test Plan:
- Reset then instr_ready=1, memory word[n]=n+32'hE000_0000 -> cycle 1 after reset release trans=2'b10 addr=0; then 2'b11 addr=1,2,3; instr_valid from cycle 3 with instr_pc 0,1,2 on consecutive cycles.
- instr_ready=0 from reset, DEPTH=4 -> exactly 4 requests (addr 0..3), then trans=2'b00; count=4; one pop -> exactly one NONSEQ request at addr 4.
- Flush with flush_pc=32'h100 while 3 entries are buffered and a response is pending -> instr_valid=0 at f+1 and f+2; f+1 trans=2'b10 addr=32'h100; f+3 instr_pc=32'h100; no stale word ever delivered.
- Pop and push in the same cycle at count=2 -> count stays 2; order preserved; check against a scoreboard of PCs.
- fetch_pc=32'hFFFFFFFE, free-running -> addresses FFFFFFFE, FFFFFFFF, 0, 1 all trans=2'b11 after the first.
- PREFETCH_ABORT_EN: abort=1 on the response for addr 5 -> entry 5 has instr_abort=1; no requests beyond addr 6; flush to 32'h20 resumes fetch.
